// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_arbiter
// Description : Round-robin arbiter for two valid/ready sources feeding a
//               one-word output register; sel drives a downstream 2:1 mux.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_arbiter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_out_data;
    logic             r_last_grant;   // 0 = A was granted last, 1 = B

    logic w_load_en;
    logic w_grant_a;
    logic w_grant_b;

    // The register can accept a new word when empty or when it drains this cycle.
    assign w_load_en = !rst && ((r_state == EMPTY) || out_ready);

    // On a tie the source that did not win last time is granted.
    assign w_grant_a = w_load_en && a_valid && (!b_valid ||  r_last_grant);
    assign w_grant_b = w_load_en && b_valid && (!a_valid || !r_last_grant);

    assign a_ready = w_grant_a;
    assign b_ready = w_grant_b;

    always_comb begin
        sel = r_last_grant;
        if (rst) begin
            sel = 1'b1;
        end else if (w_grant_b) begin
            sel = 1'b1;
        end else if (w_grant_a) begin
            sel = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= EMPTY;
            r_out_data   <= '0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_grant_a || w_grant_b) begin
                        r_state      <= FULL;
                        r_out_data   <= w_grant_b ? b_data : a_data;
                        r_last_grant <= w_grant_b;
                    end
                end
                FULL: begin
                    if (w_grant_a || w_grant_b) begin
                        r_state      <= FULL;
                        r_out_data   <= w_grant_b ? b_data : a_data;
                        r_last_grant <= w_grant_b;
                    end else if (out_ready) begin
                        r_state      <= EMPTY;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = (r_state == FULL);

endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_arbiter
// Description : Directed self-checking bench for mux_arbiter (WIDTH 8 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data, b_data, out_data;
    logic       a_valid, b_valid, a_ready, b_ready, sel, out_valid, out_ready;

    logic       a_data1, b_data1, out_data1;
    logic       a_valid1, b_valid1, a_ready1, b_ready1, sel1, out_valid1, out_ready1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mux_arbiter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .sel(sel), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_arbiter #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_data(a_data1), .a_valid(a_valid1), .a_ready(a_ready1),
        .b_data(b_data1), .b_valid(b_valid1), .b_ready(b_ready1),
        .sel(sel1), .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock edge; inputs change 1ns after it, checks run 2ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic       exp_sel;
    logic [7:0] exp_data;
    logic       mux_out;

    initial begin
        rst = 1'b1;
        a_data = 8'h00; b_data = 8'h00; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
        a_data1 = 1'b0; b_data1 = 1'b0; a_valid1 = 1'b0; b_valid1 = 1'b0; out_ready1 = 1'b0;

        // Reset: handshakes suppressed, sel forced to B, register cleared.
        step();
        a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        settle();
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_sel", sel, 1);
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_valid_w1", out_valid1, 0);

        // Single source A.
        rst = 1'b0; b_valid = 1'b0; a_data = 8'h3C;
        settle();
        check("single_a_ready", a_ready, 1);
        check("single_b_ready", b_ready, 0);
        check("single_sel", sel, 0);
        step();
        a_valid = 1'b0;
        settle();
        check("single_out_valid", out_valid, 1);
        check("single_out_data", out_data, 8'h3C);
        step();
        check("single_drained", out_valid, 0);
        check("single_hold_data", out_data, 8'h3C);

        // Tie after reset: A first, then alternate.
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hAA; b_data = 8'h55; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_sel  = (i % 2 == 1);
            exp_data = exp_sel ? 8'h55 : 8'hAA;
            settle();
            check($sformatf("tie_sel%0d", i), sel, exp_sel);
            check($sformatf("tie_onehot%0d", i), {a_ready, b_ready}, exp_sel ? 2'b01 : 2'b10);
            step();
            check($sformatf("tie_data%0d", i), out_data, exp_data);
            check($sformatf("tie_valid%0d", i), out_valid, 1);
        end

        // Load 8'h11 from A, then stall with both sources valid.
        b_valid = 1'b0; a_data = 8'h11;
        step();
        check("bp_load", out_data, 8'h11);
        out_ready = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h22; b_data = 8'h33;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("bp_a_ready%0d", i), a_ready, 0);
            check($sformatf("bp_b_ready%0d", i), b_ready, 0);
            check($sformatf("bp_sel%0d", i), sel, 0);
            step();
            check($sformatf("bp_data%0d", i), out_data, 8'h11);
            check($sformatf("bp_valid%0d", i), out_valid, 1);
        end

        // Drain with same-cycle refill from B.
        out_ready = 1'b1; a_valid = 1'b0; b_valid = 1'b1; b_data = 8'hF0;
        settle();
        check("refill_b_ready", b_ready, 1);
        check("refill_a_ready", a_ready, 0);
        check("refill_sel", sel, 1);
        step();
        check("refill_valid", out_valid, 1);
        check("refill_data", out_data, 8'hF0);

        // Reset mid-operation discards a held word.
        b_valid = 1'b0; a_valid = 1'b1; a_data = 8'h77;
        step();
        check("mid_loaded", out_data, 8'h77);
        a_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        step();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 8'h00);
        rst = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hAA; b_data = 8'h55; out_ready = 1'b1;
        settle();
        check("mid_tie_a_ready", a_ready, 1);
        check("mid_tie_sel", sel, 0);
        step();
        check("mid_tie_data", out_data, 8'hAA);
        a_valid = 1'b0; b_valid = 1'b0;
        settle();
        check("idle_sel_last", sel, 0);
        check("idle_ready", {a_ready, b_ready}, 2'b00);

        // WIDTH=1 tie: output follows the downstream mux driven by sel.
        a_valid1 = 1'b1; b_valid1 = 1'b1; a_data1 = 1'b1; b_data1 = 1'b0; out_ready1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("w1_sel%0d", i), sel1, (i % 2 == 1));
            mux_out = sel1 ? b_data1 : a_data1;
            step();
            check($sformatf("w1_data%0d", i), out_data1, (i % 2 == 0));
            check($sformatf("w1_mux%0d", i), out_data1, mux_out);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The block SHALL have parameter Width, default 1, giving the data bus width in bits (legal range 1..64).
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port a_data SHALL be an input, Width bits wide: source A payload.
REQ-005 Port a_valid SHALL be an input, 1 bit wide: source A offers a_data this cycle.
REQ-006 Port a_ready SHALL be an output, 1 bit wide: source A transfer accepted this cycle.
REQ-007 Port b_data SHALL be an input, Width bits wide: source B payload.
REQ-008 Port b_valid SHALL be an input, 1 bit wide: source B offers b_data this cycle.
REQ-009 Port b_ready SHALL be an output, 1 bit wide: source B transfer accepted this cycle.
REQ-010 Port sel SHALL be an output, 1 bit wide: select for the downstream 2:1 variable-width mux (0 = A, 1 = B).
REQ-011 Port out_data SHALL be an output, Width bits wide: registered payload of the granted source.
REQ-012 Port out_valid SHALL be an output, 1 bit wide: out_data holds an undelivered word.
REQ-013 Port out_ready SHALL be an input, 1 bit wide: consumer accepts out_data this cycle.

Function
REQ-014 A transfer on any port SHALL occur only on a cycle where that port's valid and ready are both high.
REQ-015 The FSM SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 load_en SHALL be true when the state is EMPTY, or when the state is FULL and out_ready=1 (same-cycle drain and refill).
REQ-017 With load_en true and exactly one source valid, that source SHALL be granted.
REQ-018 With load_en true and both sources valid, the source not recorded in last_grant SHALL be granted (round-robin).
REQ-019 With load_en false, or neither source valid, no grant SHALL be issued.
REQ-020 a_ready and b_ready SHALL be combinational, one-hot-or-zero, and high only for the granted source.
REQ-021 sel SHALL be 1 when B is granted and 0 when A is granted; with no grant, sel SHALL equal last_grant.
REQ-022 On a grant, at the next edge: out_data SHALL take the granted source's data, the state SHALL become FULL, and last_grant SHALL record the granted source; latency is 1 cycle.
REQ-023 When FULL with out_ready=1 and no grant, the state SHALL become EMPTY; out_data SHALL hold its last value.
REQ-024 When FULL with out_ready=0, out_data, out_valid and last_grant SHALL remain unchanged, and a_ready and b_ready SHALL both be 0.
REQ-025 Sustained throughput SHALL be one word per cycle when out_ready is held at 1.
REQ-026 A source SHALL never wait more than one grant while the other source is continuously valid (no starvation).
REQ-027 The block SHALL perform no arithmetic and no width conversion; out_data SHALL be a bit-exact copy of the granted source's data.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL set: state EMPTY, out_valid=0, out_data=0, last_grant=B (so A wins the first tie).
REQ-029 While rst=1, a_ready and b_ready SHALL be 0 and sel SHALL be 1; no transfer SHALL occur.
REQ-030 Reset asserted mid-operation SHALL discard any held word; the first cycle after rst deasserts SHALL behave as EMPTY.

Verification
REQ-031 The bench SHALL cover single source, Width=8: a_valid=1, a_data=8'h3C, b_valid=0, out_ready=1 -> a_ready=1, sel=0; next cycle out_valid=1, out_data=8'h3C.
REQ-032 The bench SHALL cover tie after reset: both valid, a_data=8'hAA, b_data=8'h55, out_ready=1 for 4 cycles -> out_data sequence AA,55,AA,55 and sel sequence 0,1,0,1.
REQ-033 The bench SHALL cover backpressure: FULL with out_data=8'h11, out_ready=0 for 3 cycles, both sources valid -> a_ready=b_ready=0 and out_data stays 8'h11 throughout.
REQ-034 The bench SHALL cover drain with refill: FULL, out_ready=1, b_valid=1 with b_data=8'hF0 -> b_ready=1 that cycle; next cycle out_valid=1, out_data=8'hF0.
REQ-035 The bench SHALL cover reset mid-operation: FULL with out_data=8'h77, rst=1 for 1 cycle -> out_valid=0, out_data=8'h00; then a tie -> A granted first.
REQ-036 The bench SHALL cover Width=1: tie with a_data=1, b_data=0 -> out_data alternates 1,0, matching the output of the downstream mux driven by sel.
